// File: rtl/keycode_encoder.sv
// PS/2 set-2 scancode encoder: turns one key event into the XX / F0 XX / E0 XX / E0 F0 XX
// byte sequence and hands the bytes out on a valid/ready link, with an optional gap per byte.
module keycode_encoder #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [7:0] keycode,
  input  logic       ext,
  input  logic       make,
  output logic       key_ready,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       seq_done,
  output logic       key_err
);

  localparam int unsigned CntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StE0, StF0, StXx, StGap} state_e;

  state_e            state_q, state_d;
  state_e            succ_q, succ_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        code_q, code_d;
  logic              make_q, make_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              seq_done_q, seq_done_d;
  logic              key_err_q, key_err_d;

  state_e            succ;
  state_e            target;
  logic              advance;

  function automatic logic [7:0] byte_of(input state_e st, input logic [7:0] code);
    case (st)
      StE0:    byte_of = 8'hE0;
      StF0:    byte_of = 8'hF0;
      default: byte_of = code;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    succ_d       = succ_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    make_d       = make_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;
    seq_done_d   = 1'b0;
    key_err_d    = 1'b0;
    advance      = 1'b0;
    target       = StIdle;
    succ         = StIdle;

    case (state_q)
      StIdle: begin
        if (key_valid) begin
          if (keycode == 8'hE0 || keycode == 8'hF0) begin
            key_err_d = 1'b1;
          end else begin
            code_d  = keycode;
            make_d  = make;
            advance = 1'b1;
            target  = ext ? StE0 : (make ? StXx : StF0);
          end
        end
      end
      StE0, StF0, StXx: begin
        if (byte_ready) begin
          case (state_q)
            StE0:    succ = make_q ? StXx : StF0;
            StF0:    succ = StXx;
            default: succ = StIdle;
          endcase
          if (GAP_CYCLES == 0) begin
            advance = 1'b1;
            target  = succ;
          end else begin
            state_d      = StGap;
            succ_d       = succ;
            cnt_d        = CntW'(GAP_CYCLES - 1);
            byte_valid_d = 1'b0;
          end
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          advance = 1'b1;
          target  = succ_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Common entry into a byte state or back to idle.
    if (advance) begin
      state_d = target;
      if (target == StIdle) begin
        byte_valid_d = 1'b0;
        seq_done_d   = 1'b1;
      end else begin
        byte_valid_d = 1'b1;
        byte_data_d  = byte_of(target, code_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      succ_q       <= StIdle;
      cnt_q        <= '0;
      code_q       <= 8'h00;
      make_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      seq_done_q   <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      succ_q       <= succ_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      make_q       <= make_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      seq_done_q   <= seq_done_d;
      key_err_q    <= key_err_d;
    end
  end

  assign key_ready  = (state_q == StIdle);
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign seq_done   = seq_done_q;
  assign key_err    = key_err_q;

endmodule

// File: tb/tb_keycode_encoder.sv
// Bench for keycode_encoder: one instance with no gap, one with a 3-cycle gap, both fed
// from the same stimulus; each test only checks the instance it targets.
module tb_keycode_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       ext = 1'b0;
  logic       make = 1'b0;
  logic       byte_ready = 1'b0;

  logic       key_ready0, byte_valid0, seq_done0, key_err0;
  logic [7:0] byte_data0;
  logic       key_ready3, byte_valid3, seq_done3, key_err3;
  logic [7:0] byte_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keycode_encoder #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .keycode(keycode), .ext(ext),
    .make(make), .key_ready(key_ready0), .byte_valid(byte_valid0), .byte_ready(byte_ready),
    .byte_data(byte_data0), .seq_done(seq_done0), .key_err(key_err0)
  );

  keycode_encoder #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .keycode(keycode), .ext(ext),
    .make(make), .key_ready(key_ready3), .byte_valid(byte_valid3), .byte_ready(byte_ready),
    .byte_data(byte_data3), .seq_done(seq_done3), .key_err(key_err3)
  );

  typedef struct {
    logic [7:0]      code;
    logic            e;
    logic            m;
    int              len;
    logic [2:0][7:0] bytes;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One-cycle key_valid pulse; returns at the negedge after the accepting edge.
  task automatic drive_key(input logic [7:0] c, input logic e, input logic m);
    key_valid = 1'b1;
    keycode   = c;
    ext       = e;
    make      = m;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{code: 8'h1C, e: 1'b0, m: 1'b1, len: 1, bytes: {8'h00, 8'h00, 8'h1C}};
    vecs[1] = '{code: 8'h1C, e: 1'b0, m: 1'b0, len: 2, bytes: {8'h00, 8'h1C, 8'hF0}};
    vecs[2] = '{code: 8'h75, e: 1'b1, m: 1'b1, len: 2, bytes: {8'h00, 8'h75, 8'hE0}};
    vecs[3] = '{code: 8'h75, e: 1'b1, m: 1'b0, len: 3, bytes: {8'h75, 8'hF0, 8'hE0}};
    vecs[4] = '{code: 8'hFF, e: 1'b0, m: 1'b1, len: 1, bytes: {8'h00, 8'h00, 8'hFF}};
    vecs[5] = '{code: 8'h00, e: 1'b1, m: 1'b0, len: 3, bytes: {8'h00, 8'hF0, 8'hE0}};

    // Reset state, sampled while reset is still held.
    @(negedge clk);
    @(negedge clk);
    chk("rst key_ready0", key_ready0, 1);
    chk("rst byte_valid0", byte_valid0, 0);
    chk("rst byte_data0", byte_data0, 8'h00);
    chk("rst seq_done0", seq_done0, 0);
    chk("rst key_err0", key_err0, 0);
    chk("rst key_ready3", key_ready3, 1);
    chk("rst byte_valid3", byte_valid3, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back encoding, no gap, transmitter always ready.
    byte_ready = 1'b1;
    foreach (vecs[i]) begin
      drive_key(vecs[i].code, vecs[i].e, vecs[i].m);
      for (int k = 0; k < vecs[i].len; k++) begin
        chk($sformatf("v%0d b%0d valid", i, k), byte_valid0, 1);
        chk($sformatf("v%0d b%0d data", i, k), byte_data0, vecs[i].bytes[k]);
        chk($sformatf("v%0d b%0d done", i, k), seq_done0, 0);
        chk($sformatf("v%0d b%0d ready", i, k), key_ready0, 0);
        @(negedge clk);
      end
      chk($sformatf("v%0d end valid", i), byte_valid0, 0);
      chk($sformatf("v%0d end done", i), seq_done0, 1);
      chk($sformatf("v%0d end ready", i), key_ready0, 1);
      @(negedge clk);
      chk($sformatf("v%0d done pulse", i), seq_done0, 0);
    end

    // Illegal keycodes are dropped with a one-cycle key_err.
    drive_key(8'hF0, 1'b0, 1'b1);
    chk("illF0 key_err", key_err0, 1);
    chk("illF0 valid", byte_valid0, 0);
    chk("illF0 ready", key_ready0, 1);
    drive_key(8'hE0, 1'b1, 1'b0);
    chk("illE0 key_err", key_err0, 1);
    chk("illE0 valid", byte_valid0, 0);
    @(negedge clk);
    chk("ill key_err end", key_err0, 0);
    chk("ill valid end", byte_valid0, 0);
    chk("ill done", seq_done0, 0);

    // Stalled transmitter; inputs changed after acceptance must not matter.
    byte_ready = 1'b0;
    drive_key(8'h1C, 1'b0, 1'b0);
    keycode = 8'h55;
    ext     = 1'b1;
    make    = 1'b1;
    for (int j = 0; j < 2; j++) begin
      logic [7:0] exp_b;
      exp_b = (j == 0) ? 8'hF0 : 8'h1C;
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("stall b%0d c%0d valid", j, c), byte_valid0, 1);
        chk($sformatf("stall b%0d c%0d data", j, c), byte_data0, exp_b);
        @(negedge clk);
      end
      byte_ready = 1'b1;
      chk($sformatf("stall b%0d xfer data", j), byte_data0, exp_b);
      @(negedge clk);
      byte_ready = 1'b0;
    end
    chk("stall done", seq_done0, 1);
    chk("stall valid end", byte_valid0, 0);

    // Reset with F0 pending abandons the sequence.
    pulse_reset();
    byte_ready = 1'b0;
    drive_key(8'h1C, 1'b0, 1'b0);
    chk("midrst pending valid", byte_valid0, 1);
    chk("midrst pending data", byte_data0, 8'hF0);
    reset_n    = 1'b0;
    key_valid  = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    reset_n   = 1'b1;
    key_valid = 1'b0;
    chk("midrst valid", byte_valid0, 0);
    chk("midrst data", byte_data0, 8'h00);
    chk("midrst ready", key_ready0, 1);
    chk("midrst done", seq_done0, 0);
    @(negedge clk);
    chk("midrst done later", seq_done0, 0);
    chk("midrst valid later", byte_valid0, 0);
    drive_key(8'h1C, 1'b0, 1'b1);
    chk("postrst valid", byte_valid0, 1);
    chk("postrst data", byte_data0, 8'h1C);
    @(negedge clk);
    chk("postrst done", seq_done0, 1);

    // GAP_CYCLES=3 instance, key_valid held high throughout.
    pulse_reset();
    byte_ready = 1'b1;
    key_valid  = 1'b1;
    keycode    = 8'h6B;
    ext        = 1'b1;
    make       = 1'b1;
    @(negedge clk);
    keycode = 8'h1C;
    ext     = 1'b0;
    chk("gap E0 valid", byte_valid3, 1);
    chk("gap E0 data", byte_data3, 8'hE0);
    chk("gap E0 ready", key_ready3, 0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("gap1 c%0d valid", g), byte_valid3, 0);
      chk($sformatf("gap1 c%0d ready", g), key_ready3, 0);
      @(negedge clk);
    end
    chk("gap 6B valid", byte_valid3, 1);
    chk("gap 6B data", byte_data3, 8'h6B);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("gap2 c%0d valid", g), byte_valid3, 0);
      chk($sformatf("gap2 c%0d done", g), seq_done3, 0);
      chk($sformatf("gap2 c%0d ready", g), key_ready3, 0);
      @(negedge clk);
    end
    chk("gap done", seq_done3, 1);
    chk("gap ready", key_ready3, 1);
    @(negedge clk);
    key_valid = 1'b0;
    chk("gap reaccept valid", byte_valid3, 1);
    chk("gap reaccept data", byte_data3, 8'h1C);
    chk("gap reaccept done", seq_done3, 0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("gap3 c%0d valid", g), byte_valid3, 0);
      @(negedge clk);
    end
    chk("gap2 done", seq_done3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
